// File: rtl/pll_reset_seq_if.sv
// Control/status bundle between the PLL reset sequencer and its surroundings.
// The sequencer side uses the master modport; the PLL/system side uses slave.
interface pll_reset_seq_if #(
    parameter int NUM_STAGES = 3
);
    logic                  locked_in;
    logic                  clear_status;
    logic                  pll_rst;
    logic [NUM_STAGES-1:0] rstb_out;
    logic                  ready;
    logic                  lost_lock;
    logic [7:0]            retry_count;
    logic                  fail;

    modport master (
        input  locked_in,
        input  clear_status,
        output pll_rst,
        output rstb_out,
        output ready,
        output lost_lock,
        output retry_count,
        output fail
    );

    modport slave (
        output locked_in,
        output clear_status,
        input  pll_rst,
        input  rstb_out,
        input  ready,
        input  lost_lock,
        input  retry_count,
        input  fail
    );
endinterface

// File: rtl/pll_reset_seq.sv
// PLL reset sequencer: pulses the PLL reset, qualifies LOCKED, retries on timeout
// and releases staged active-low domain resets once lock has been stable.
module pll_reset_seq #(
    parameter int PLL_RST_CYCLES      = 16,
    parameter int LOCK_TIMEOUT_CYCLES = 65536,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int NUM_STAGES          = 3,
    parameter int STAGE_GAP           = 16,
    parameter int MAX_RETRIES         = 0,
    parameter int CNT_WIDTH           = 20
) (
    input logic             clk,
    input logic             resetb,
    pll_reset_seq_if.master bus
);

    typedef enum logic [2:0] {
        ST_PLL_RESET = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_QUALIFY   = 3'd2,
        ST_RELEASE   = 3'd3,
        ST_RUN       = 3'd4,
        ST_FAIL      = 3'd5
    } state_e;

    localparam logic [CNT_WIDTH-1:0] RST_LAST     = CNT_WIDTH'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] TIMEOUT_LAST = CNT_WIDTH'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] STABLE_LAST  = CNT_WIDTH'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] RELEASE_LAST = CNT_WIDTH'(STAGE_GAP * NUM_STAGES - 1);

    state_e                 state_q, state_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic [1:0]             sync_q, sync_d;
    logic                   locked_s;

    logic                   pll_rst_q, pll_rst_d;
    logic [NUM_STAGES-1:0]  rstb_q, rstb_d;
    logic                   ready_q, ready_d;
    logic                   lost_lock_q, lost_lock_d;
    logic [7:0]             retry_q, retry_d;
    logic                   fail_q, fail_d;

    logic                   timeout_hit;
    logic                   lock_drop;
    logic [7:0]             retry_sat;

    // locked_in is asynchronous to clk; only the second flop is ever looked at.
    assign sync_d   = {sync_q[0], bus.locked_in};
    assign locked_s = sync_q[1];

    assign retry_sat = (retry_q == 8'hFF) ? 8'hFF : retry_q + 8'd1;

    // Next-state logic.
    // NOTE: every signal written here gets a default first so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        timeout_hit = 1'b0;
        lock_drop   = 1'b0;
        unique case (state_q)
            ST_PLL_RESET: begin
                if (cnt_q == RST_LAST) state_d = ST_WAIT_LOCK;
            end
            ST_WAIT_LOCK: begin
                if (locked_s) begin
                    state_d = ST_QUALIFY;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    timeout_hit = 1'b1;
                    if (MAX_RETRIES != 0 && {24'd0, retry_sat} >= 32'(MAX_RETRIES))
                        state_d = ST_FAIL;
                    else
                        state_d = ST_PLL_RESET;
                end
            end
            ST_QUALIFY: begin
                if (!locked_s)                 state_d = ST_WAIT_LOCK;
                else if (cnt_q == STABLE_LAST) state_d = ST_RELEASE;
            end
            ST_RELEASE: begin
                if (!locked_s) begin
                    lock_drop = 1'b1;
                    state_d   = ST_PLL_RESET;
                end else if (cnt_q == RELEASE_LAST) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!locked_s) begin
                    lock_drop = 1'b1;
                    state_d   = ST_PLL_RESET;
                end
            end
            ST_FAIL: begin
                if (bus.clear_status) state_d = ST_PLL_RESET;
            end
            default: state_d = ST_PLL_RESET;
        endcase
    end

    // Every transition targets a different state, so a state change marks entry.
    assign cnt_d = (state_d != state_q) ? '0 : cnt_q + CNT_WIDTH'(1);

    // A lost-lock set beats a same-cycle clear; a clear beats a same-cycle retry increment.
    always_comb begin
        lost_lock_d = lost_lock_q;
        if (lock_drop)             lost_lock_d = 1'b1;
        else if (bus.clear_status) lost_lock_d = 1'b0;

        retry_d = retry_q;
        if (bus.clear_status) retry_d = 8'd0;
        else if (timeout_hit) retry_d = retry_sat;
    end

    // Outputs are decoded from the upcoming state so they are valid on its first cycle.
    always_comb begin
        pll_rst_d = 1'b0;
        rstb_d    = '0;
        ready_d   = 1'b0;
        fail_d    = 1'b0;
        unique case (state_d)
            ST_PLL_RESET: pll_rst_d = 1'b1;
            ST_RELEASE: begin
                for (int i = 0; i < NUM_STAGES; i++)
                    rstb_d[i] = (cnt_d >= CNT_WIDTH'(STAGE_GAP * (i + 1) - 1));
            end
            ST_RUN: begin
                rstb_d  = '1;
                ready_d = 1'b1;
            end
            ST_FAIL: begin
                pll_rst_d = 1'b1;
                fail_d    = 1'b1;
            end
            default: ;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state_q     <= ST_PLL_RESET;
            cnt_q       <= '0;
            sync_q      <= '0;
            pll_rst_q   <= 1'b1;
            rstb_q      <= '0;
            ready_q     <= 1'b0;
            lost_lock_q <= 1'b0;
            retry_q     <= 8'd0;
            fail_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sync_q      <= sync_d;
            pll_rst_q   <= pll_rst_d;
            rstb_q      <= rstb_d;
            ready_q     <= ready_d;
            lost_lock_q <= lost_lock_d;
            retry_q     <= retry_d;
            fail_q      <= fail_d;
        end
    end

    assign bus.pll_rst     = pll_rst_q;
    assign bus.rstb_out    = rstb_q;
    assign bus.ready       = ready_q;
    assign bus.lost_lock   = lost_lock_q;
    assign bus.retry_count = retry_q;
    assign bus.fail        = fail_q;

endmodule
